// File: rtl/bpg_status_pkg.sv
// Shared defaults and status-word bit map for the BPG status/event bank.
// Host driver code and benches use the same offsets to decode the status word.
package bpg_status_pkg;

  localparam int DEF_NUM_LEVEL     = 6;
  localparam int DEF_NUM_STICKY    = 4;
  localparam int DEF_WIDTH         = 16;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CLEAR_ON_READ = 1;
  localparam int DEF_CNT_W         = 8;

  localparam int LEVEL_LSB  = 0;
  localparam int STICKY_LSB = DEF_NUM_LEVEL;

  // The sticky field sits directly above the level field for any level count.
  function automatic int sticky_lsb(input int num_level);
    return LEVEL_LSB + num_level;
  endfunction

endpackage

// File: rtl/bpg_sync_edge.sv
// Multi-bit synchroniser followed by a rising-edge detector.
// q is the synchronised level; rise is a registered one-cycle pulse per 0->1 transition.
module bpg_sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] s_d;

  // NOTE: synchroniser flops are ordinary registers, not a memory, so every
  // stage is cleared by reset; no stale level can leak out after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      s_d  <= '0;
      rise <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      s_d  <= chain[STAGES-1];
      rise <= chain[STAGES-1] & ~s_d;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/status_event_bank.sv
// Host-readable status word: synchronised live levels plus sticky edge events
// with clear-on-read / write-1-to-clear, maskable irq and a saturating overrun count.
module status_event_bank
  import bpg_status_pkg::*;
#(
  parameter int NUM_LEVEL     = DEF_NUM_LEVEL,
  parameter int NUM_STICKY    = DEF_NUM_STICKY,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CLEAR_ON_READ = DEF_CLEAR_ON_READ,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVEL-1:0]  level_in,
  input  logic [NUM_STICKY-1:0] event_in,
  input  logic                  hold,
  input  logic                  rd_strobe,
  input  logic                  wr_en,
  input  logic [NUM_STICKY-1:0] wr_data,
  input  logic                  cnt_clr,
  input  logic [NUM_STICKY-1:0] irq_mask,
  output logic [WIDTH-1:0]      status,
  output logic                  irq,
  output logic [CNT_W-1:0]      overrun_count
);

  localparam int STICKY_OFF = sticky_lsb(NUM_LEVEL);

  if (NUM_LEVEL + NUM_STICKY > WIDTH) begin : g_bad_width
    $error("status_event_bank: NUM_LEVEL+NUM_STICKY exceeds WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("status_event_bank: SYNC_STAGES must be at least 2");
  end

  logic [NUM_LEVEL-1:0]  level_s;
  logic [NUM_STICKY-1:0] event_s;
  logic [NUM_STICKY-1:0] event_rise;

  bpg_sync_edge #(.W(NUM_LEVEL), .STAGES(SYNC_STAGES)) u_level_sync (
    .clk  (clk),
    .reset(reset),
    .d    (level_in),
    .q    (level_s),
    .rise ()
  );

  bpg_sync_edge #(.W(NUM_STICKY), .STAGES(SYNC_STAGES)) u_event_sync (
    .clk  (clk),
    .reset(reset),
    .d    (event_in),
    .q    (event_s),
    .rise (event_rise)
  );

  logic [NUM_LEVEL-1:0]  level_q;
  logic [NUM_STICKY-1:0] sticky;
  logic [NUM_STICKY-1:0] clr;
  logic [NUM_STICKY-1:0] sticky_next;
  logic                  overrun_hit;
  logic                  irq_q;
  logic [CNT_W-1:0]      cnt_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    clr         = '0;
    sticky_next = sticky;
    overrun_hit = 1'b0;
    if (wr_en) clr = clr | wr_data;
    // Read-clear covers only what the host saw: sticky is the presented field.
    if ((CLEAR_ON_READ != 0) && rd_strobe) clr = clr | sticky;
    sticky_next = (sticky & ~clr) | event_rise;
    overrun_hit = |(event_rise & sticky & ~clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      sticky  <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (!hold) level_q <= level_s;
      sticky <= sticky_next;
      irq_q  <= |(sticky_next & irq_mask);
      if (cnt_clr)
        cnt_q <= '0;
      else if (overrun_hit && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    status = '0;
    status[LEVEL_LSB +: NUM_LEVEL]   = level_q;
    status[STICKY_OFF +: NUM_STICKY] = sticky;
  end

  assign irq           = irq_q;
  assign overrun_count = cnt_q;

endmodule
